i2c_cmd_scheduler: RTL and testbench

Sequencer between the command FIFOs (address/op/data1/data2/valid) and the I2C controller of the digital thermometer.
- Pops one queued command at a time and issues it to the I2C core with a start/done handshake.
- Supervises each transaction with a timeout.
- Returns read data bytewise to the UART transmitter.
- Signals completion or error per command.

---
 rtl/i2c_sched_pkg.sv | 25 ++
 rtl/i2c_cmd_scheduler_txn_timer.sv | 31 +++
 rtl/i2c_cmd_scheduler.sv | 163 ++++++++++++++++
 tb/tb_i2c_cmd_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_sched_pkg.sv
// Shared types for the I2C command scheduler: FSM states, command modes and mode checks.
package i2c_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_SEND_MSB = 3'd4,
    ST_SEND_LSB = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam logic [2:0] MODE_PTR = 3'b000;
  localparam logic [2:0] MODE_WR1 = 3'b001;
  localparam logic [2:0] MODE_WR2 = 3'b010;
  localparam logic [2:0] MODE_RD1 = 3'b011;
  localparam logic [2:0] MODE_RD2 = 3'b100;

  // Codes above MODE_RD2 have no I2C meaning and are rejected before issue.
  function automatic logic is_legal_mode(input logic [2:0] mode);
    return (mode <= MODE_RD2);
  endfunction

endpackage

// File: rtl/i2c_cmd_scheduler_txn_timer.sv
// Transaction timer: loadable up-counter with clear, enable and terminal-count flag.
module txn_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VALUE);

endmodule

// File: rtl/i2c_cmd_scheduler.sv
// Pops queued commands, runs each on the I2C core under a timeout and streams read bytes to the UART.
// Build option: define I2C_RETRY_EN to reissue NACKed commands up to MAX_RETRIES times.
module i2c_cmd_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
`ifdef I2C_RETRY_EN
  , parameter int MAX_RETRIES  = 2
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_empty,
  output logic        cmd_rd,
  input  logic [2:0]  cmd_mode,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic        i2c_ready,
  output logic        i2c_start,
  output logic [2:0]  i2c_mode,
  output logic [7:0]  i2c_addr,
  output logic [15:0] i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic [15:0] i2c_rdata,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  data_byte,
  output logic        op_complete,
  output logic        op_error,
  output logic        time_out,
  output logic        busy
);

  // Handshakes: cmd_rd pops one command whose fields are valid the following
  // cycle; i2c_start is a one-cycle request accepted only while i2c_ready is
  // high, answered by a one-cycle i2c_done that qualifies i2c_nack/i2c_rdata;
  // tx_start is a one-cycle byte send issued only while tx_ready is high.

  state_t      state;
  state_t      state_next;
  logic [15:0] rdata_q;
  logic        err_flag;
  logic        tc;

  logic pop;
  logic issue_start;
  logic nack_hit;
  logic done_ok;
  logic timeout_hit;
  logic retry_ok;
  logic set_err;

  assign pop         = (state == ST_IDLE) && !cmd_empty && i2c_ready && !reset;
  assign issue_start = (state == ST_ISSUE) && i2c_ready;
  assign nack_hit    = (state == ST_WAIT) && i2c_done && i2c_nack;
  assign done_ok     = (state == ST_WAIT) && i2c_done && !i2c_nack;
  // A completion arriving on the terminal cycle beats the timeout.
  assign timeout_hit = (state == ST_WAIT) && !i2c_done && tc;
  assign set_err     = timeout_hit || (nack_hit && !retry_ok);

`ifdef I2C_RETRY_EN
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RETRY_W-1:0] retry_cnt;

  assign retry_ok = (int'(retry_cnt) < MAX_RETRIES);

  always_ff @(posedge clk) begin
    if (reset || state == ST_LATCH) begin
      retry_cnt <= '0;
    end else if (nack_hit && retry_ok) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  txn_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (issue_start),
    .load       (1'b0),
    .load_value ('0),
    .enable     (state == ST_WAIT),
    .tc         (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (pop) state_next = ST_LATCH;
      ST_LATCH: state_next = is_legal_mode(cmd_mode) ? ST_ISSUE : ST_DONE;
      ST_ISSUE: if (i2c_ready) state_next = ST_WAIT;
      ST_WAIT: begin
        if (i2c_done) begin
          if (i2c_nack)                state_next = retry_ok ? ST_ISSUE : ST_DONE;
          else if (i2c_mode == MODE_RD2) state_next = ST_SEND_MSB;
          else if (i2c_mode == MODE_RD1) state_next = ST_SEND_LSB;
          else                         state_next = ST_DONE;
        end else if (tc) begin
          state_next = ST_DONE;
        end
      end
      ST_SEND_MSB: if (tx_ready) state_next = ST_SEND_LSB;
      ST_SEND_LSB: if (tx_ready) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_rd      = pop;
    i2c_start   = issue_start;
    tx_start    = ((state == ST_SEND_MSB) || (state == ST_SEND_LSB)) && tx_ready;
    data_byte   = 8'h00;
    op_complete = (state == ST_DONE);
    op_error    = (state == ST_DONE) && err_flag;
    busy        = (state != ST_IDLE);
    if (state == ST_SEND_MSB)      data_byte = rdata_q[15:8];
    else if (state == ST_SEND_LSB) data_byte = rdata_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i2c_mode  <= '0;
      i2c_addr  <= '0;
      i2c_wdata <= '0;
      rdata_q   <= '0;
      err_flag  <= 1'b0;
      time_out  <= 1'b0;
    end else begin
      if (pop)              time_out <= 1'b0;
      else if (timeout_hit) time_out <= 1'b1;

      if (state == ST_LATCH) begin
        i2c_mode  <= cmd_mode;
        i2c_addr  <= cmd_addr;
        i2c_wdata <= cmd_data;
        err_flag  <= !is_legal_mode(cmd_mode);
      end else if (set_err) begin
        err_flag <= 1'b1;
      end

      if (done_ok && ((i2c_mode == MODE_RD1) || (i2c_mode == MODE_RD2))) begin
        rdata_q <= i2c_rdata;
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_scheduler.sv
// Directed bench for i2c_cmd_scheduler: FIFO model, I2C responder, event monitor with byte scoreboard.
module tb_i2c_cmd_scheduler;

  localparam int TIMEOUT = 16;
`ifdef I2C_RETRY_EN
  localparam int EXP_NACK_STARTS = 3;
`else
  localparam int EXP_NACK_STARTS = 1;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_empty = 1'b1;
  logic        cmd_rd;
  logic [2:0]  cmd_mode;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        i2c_ready = 1'b1;
  logic        i2c_start;
  logic [2:0]  i2c_mode;
  logic [7:0]  i2c_addr;
  logic [15:0] i2c_wdata;
  logic        i2c_done  = 1'b0;
  logic        i2c_nack  = 1'b0;
  logic [15:0] i2c_rdata = 16'h0000;
  logic        tx_ready  = 1'b1;
  logic        tx_start;
  logic [7:0]  data_byte;
  logic        op_complete;
  logic        op_error;
  logic        time_out;
  logic        busy;

  i2c_cmd_scheduler #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_empty   (cmd_empty),
    .cmd_rd      (cmd_rd),
    .cmd_mode    (cmd_mode),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .i2c_ready   (i2c_ready),
    .i2c_start   (i2c_start),
    .i2c_mode    (i2c_mode),
    .i2c_addr    (i2c_addr),
    .i2c_wdata   (i2c_wdata),
    .i2c_done    (i2c_done),
    .i2c_nack    (i2c_nack),
    .i2c_rdata   (i2c_rdata),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .data_byte   (data_byte),
    .op_complete (op_complete),
    .op_error    (op_error),
    .time_out    (time_out),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // command FIFO model: head register updates on pop, so fields are valid the cycle after cmd_rd
  logic [26:0] cmd_q[$];
  logic [26:0] fifo_head = '0;
  assign {cmd_mode, cmd_addr, cmd_data} = fifo_head;

  always @(posedge clk) begin
    if (cmd_rd && cmd_q.size() > 0) fifo_head <= cmd_q.pop_front();
    #2 cmd_empty = (cmd_q.size() == 0);
  end

  // I2C core responder: answers each start after resp_delay cycles unless reset intervenes
  logic        resp_en    = 1'b1;
  int          resp_delay = 3;
  logic        resp_nack  = 1'b0;
  logic [15:0] resp_rdata = 16'h0000;
  logic        r_abort;

  always begin
    @(negedge clk);
    if (i2c_start && resp_en) begin
      r_abort = 1'b0;
      for (int k = 0; k < resp_delay; k++) begin
        @(posedge clk);
        if (reset) begin
          r_abort = 1'b1;
          break;
        end
      end
      if (!r_abort) begin
        #1;
        i2c_done  = 1'b1;
        i2c_nack  = resp_nack;
        i2c_rdata = resp_rdata;
        @(posedge clk);
        #1;
        i2c_done  = 1'b0;
        i2c_nack  = 1'b0;
      end
    end
  end

  // monitor and scoreboard
  logic [7:0] exp_q[$];
  int   cyc = 0;
  int   n_rd = 0, n_start = 0, n_tx = 0, n_opc = 0;
  int   last_rd_cyc = 0, last_start_cyc = 0, last_opc_cyc = 0;
  logic last_err = 1'b0, last_to = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (cmd_rd) begin
      n_rd++;
      last_rd_cyc = cyc;
      check("pop_while_busy", {31'd0, busy}, 32'd0);
    end
    if (i2c_start) begin
      n_start++;
      last_start_cyc = cyc;
    end
    if (tx_start) begin
      n_tx++;
      check("tx_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("tx_byte", {24'd0, data_byte}, {24'd0, exp_q.pop_front()});
    end
    if (op_error) check("err_without_complete", {31'd0, op_complete}, 32'd1);
    if (op_complete) begin
      n_opc++;
      last_opc_cyc = cyc;
      last_err = op_error;
      last_to  = time_out;
    end
  end

  // driver tasks
  task automatic cyc_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_look();
    @(negedge clk);
    #1;
  endtask

  function automatic int evt_count(input int sel);
    case (sel)
      0:       return n_rd;
      1:       return n_start;
      default: return n_opc;
    endcase
  endfunction

  task automatic wait_evt(input string tag, input int sel, input int target, input int limit);
    int k;
    k = 0;
    while (evt_count(sel) < target && k < limit) begin
      cyc_look();
      k++;
    end
    check(tag, {31'd0, evt_count(sel) >= target}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {25'd0, cmd_rd, i2c_start, tx_start, op_complete, op_error, time_out, busy}, 32'd0);
    check({tag, "_mode"}, {29'd0, i2c_mode}, 32'd0);
    check({tag, "_addr"}, {24'd0, i2c_addr}, 32'd0);
    check({tag, "_wdata"}, {16'd0, i2c_wdata}, 32'd0);
    check({tag, "_byte"}, {24'd0, data_byte}, 32'd0);
  endtask

  int b_rd, b_start, b_tx, b_opc;

  task automatic snap();
    b_rd = n_rd; b_start = n_start; b_tx = n_tx; b_opc = n_opc;
  endtask

  initial begin
    // reset state
    repeat (3) cyc_look();
    check_all_zero("reset");
    cyc_drive();
    reset = 1'b0;
    cyc_look();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // two-byte read, done 10 cycles after start
    snap();
    resp_delay = 10; resp_rdata = 16'h1A80; resp_nack = 1'b0;
    exp_q.push_back(8'h1A);
    exp_q.push_back(8'h80);
    cmd_q.push_back({3'b100, 8'h00, 16'h0000});
    wait_evt("rd2_opc", 2, b_opc + 1, 100);
    check("rd2_starts", n_start - b_start, 1);
    check("rd2_tx_count", n_tx - b_tx, 2);
    check("rd2_err", {31'd0, last_err}, 32'd0);
    check("rd2_latency", last_start_cyc - last_rd_cyc, 2);
    check("rd2_length", last_opc_cyc - last_start_cyc, 13);
    cyc_look();
    check("rd2_opc_pulse", {30'd0, op_complete, busy}, 32'd0);

    // one-byte read with UART held busy: byte must stay on data_byte
    snap();
    tx_ready = 1'b0; resp_delay = 3; resp_rdata = 16'h1234;
    exp_q.push_back(8'h34);
    cmd_q.push_back({3'b011, 8'h03, 16'h0000});
    wait_evt("rd1_start", 1, b_start + 1, 50);
    repeat (8) cyc_look();
    check("rd1_hold_tx", n_tx - b_tx, 0);
    check("rd1_hold_byte", {24'd0, data_byte}, 32'h34);
    check("rd1_hold_busy", {31'd0, busy}, 32'd1);
    cyc_drive();
    tx_ready = 1'b1;
    wait_evt("rd1_opc", 2, b_opc + 1, 50);
    check("rd1_tx_count", n_tx - b_tx, 1);
    check("rd1_err", {31'd0, last_err}, 32'd0);

    // single-byte write
    snap();
    resp_delay = 3;
    cmd_q.push_back({3'b001, 8'h01, 16'h0060});
    wait_evt("wr1_opc", 2, b_opc + 1, 50);
    check("wr1_wdata", {16'd0, i2c_wdata}, 32'h0060);
    check("wr1_addr", {24'd0, i2c_addr}, 32'h01);
    check("wr1_mode", {29'd0, i2c_mode}, 32'h1);
    check("wr1_latency", last_start_cyc - last_rd_cyc, 2);
    check("wr1_length", last_opc_cyc - last_start_cyc, 4);
    check("wr1_tx_count", n_tx - b_tx, 0);
    check("wr1_err", {31'd0, last_err}, 32'd0);

    // timeout: no i2c_done
    snap();
    resp_en = 1'b0;
    cmd_q.push_back({3'b010, 8'h04, 16'hCAFE});
    wait_evt("to_opc", 2, b_opc + 1, 100);
    check("to_starts", n_start - b_start, 1);
    check("to_length", last_opc_cyc - last_start_cyc, 17);
    check("to_err", {31'd0, last_err}, 32'd1);
    check("to_flag", {31'd0, last_to}, 32'd1);
    cyc_look();
    check("to_sticky", {31'd0, time_out}, 32'd1);
    resp_en = 1'b1;

    // illegal mode: no I2C traffic, error two cycles after pop; pop clears time_out
    snap();
    cmd_q.push_back({3'b110, 8'h07, 16'h1111});
    wait_evt("ill_opc", 2, b_opc + 1, 50);
    check("ill_starts", n_start - b_start, 0);
    check("ill_length", last_opc_cyc - last_rd_cyc, 2);
    check("ill_err", {31'd0, last_err}, 32'd1);
    check("ill_timeout_cleared", {31'd0, time_out}, 32'd0);

    // NACK on a one-byte read
    snap();
    resp_nack = 1'b1; resp_delay = 2;
    cmd_q.push_back({3'b011, 8'h02, 16'h0000});
    wait_evt("nack_opc", 2, b_opc + 1, 200);
    check("nack_starts", n_start - b_start, EXP_NACK_STARTS);
    check("nack_err", {31'd0, last_err}, 32'd1);
    check("nack_tx_count", n_tx - b_tx, 0);
    check("nack_no_timeout", {31'd0, last_to}, 32'd0);
    resp_nack = 1'b0;

    // three queued commands, core not ready at first, reset during second WAIT
    snap();
    i2c_ready = 1'b0; resp_delay = 4;
    cmd_q.push_back({3'b010, 8'h02, 16'hBEEF});
    cmd_q.push_back({3'b100, 8'h10, 16'h0000});
    cmd_q.push_back({3'b000, 8'h05, 16'h0042});
    repeat (5) cyc_look();
    check("b2b_no_pop_not_ready", n_rd - b_rd, 0);
    check("b2b_idle_not_ready", {31'd0, busy}, 32'd0);
    cyc_drive();
    i2c_ready = 1'b1;
    wait_evt("b2b_c1_opc", 2, b_opc + 1, 100);
    check("b2b_c1_err", {31'd0, last_err}, 32'd0);
    resp_delay = 30;
    wait_evt("b2b_c2_start", 1, b_start + 2, 50);
    cyc_drive();
    reset = 1'b1;
    cyc_drive();
    cyc_look();
    check_all_zero("midreset");
    check("b2b_pops_mid", n_rd - b_rd, 2);
    check("b2b_no_opc_c2", n_opc - b_opc, 1);
    cyc_drive();
    reset = 1'b0;
    resp_delay = 4;
    wait_evt("b2b_c3_opc", 2, b_opc + 2, 100);
    check("b2b_pops_total", n_rd - b_rd, 3);
    check("b2b_c3_err", {31'd0, last_err}, 32'd0);
    check("b2b_c3_mode", {29'd0, i2c_mode}, 32'h0);
    check("b2b_c3_addr", {24'd0, i2c_addr}, 32'h05);
    check("b2b_c3_wdata", {16'd0, i2c_wdata}, 32'h0042);

    repeat (3) cyc_look();
    check("final_opc_total", n_opc - b_opc, 2);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
